// File: rtl/pipelined_csum_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined
// conditional-sum adder: operation encodings, tree depth, and the
// offset/width of any node in the recursive split tree.
package pipelined_csum_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit range covered by one node of the split tree.
  typedef struct packed {
    int off;
    int w;
  } csum_node_t;

  // Number of halvings until every chunk is at most k bits wide.
  // The widest chunk at each depth is always the LO half.
  function automatic int csum_depth(input int n, input int k);
    int w;
    int d;
    w = n;
    d = 0;
    while (w > k) begin
      w = w - (w / 2);
      d = d + 1;
    end
    return d;
  endfunction

  // Offset/width of node idx at tree level lvl. Bit (lvl-1-s) of idx
  // chooses the HI half (1) or the LO half (0) at split s; LO sits at
  // the lower bit positions and takes the extra bit of an odd width.
  function automatic csum_node_t csum_node(input int n, input int lvl, input int idx);
    csum_node_t r;
    int hi;
    r.off = 0;
    r.w   = n;
    for (int s = lvl - 1; s >= 0; s--) begin
      hi = r.w / 2;
      if (((idx >> s) & 1) != 0) begin
        r.off = r.off + (r.w - hi);
        r.w   = hi;
      end else begin
        r.w   = r.w - hi;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_conditional_sum_adder_leaf.sv
// Leaf of the conditional-sum tree: adds one chunk under both carry-in
// hypotheses so that the merge levels only ever select, never add.
module csum_leaf #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y0,
  output logic         o_c0,
  output logic [W-1:0] o_y1,
  output logic         o_c1
);

  assign {o_c0, o_y0} = {1'b0, i_a} + {1'b0, i_b};
  assign {o_c1, o_y1} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/pipelined_conditional_sum_adder.sv
// Pipelined conditional-sum adder/subtractor with a valid/ready stream.
// Level D of the tree is the leaves (registered in stage 0); each
// register stage after that merges one level. Level 0 is the whole word,
// and the output register picks its carry-in 0 or carry-in 1 result
// using the effective carry that travelled alongside the operation.
module pipelined_conditional_sum_adder
  import pipelined_csum_pkg::*;
#(
  parameter int N     = 64,
  parameter int K     = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             cin,
  input  logic             op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     y,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int D  = csum_depth(N, K);
  localparam int DS = (D > 0) ? D : 1;
  localparam int NL = 1 << D;

  logic                 w_adv;
  logic [N-1:0]         w_b_eff;
  logic                 w_c_eff;

  // Per tree level: node sums for both hypotheses (flat, one bit range per
  // node), node carries (one bit per node) and the sideband entering the
  // register that holds that level.
  logic [N-1:0]         w_y0   [0:D];
  logic [N-1:0]         w_y1   [0:D];
  logic [NL-1:0]        w_c0   [0:D];
  logic [NL-1:0]        w_c1   [0:D];
  logic                 w_ceff [0:D];
  logic [TAG_W-1:0]     w_tag  [0:D];
  logic                 w_as   [0:D];
  logic                 w_bs   [0:D];
  logic                 w_vld  [0:D];

  logic [N-1:0]         w_ly0, w_ly1;
  logic [NL-1:0]        w_lc0, w_lc1;

  // Registered tree levels 1..D (level D = stage 0, level 1 = stage D-1).
  logic [N-1:0]         r_y0   [1:DS];
  logic [N-1:0]         r_y1   [1:DS];
  logic [NL-1:0]        r_c0   [1:DS];
  logic [NL-1:0]        r_c1   [1:DS];
  logic                 r_ceff [1:DS];
  logic [TAG_W-1:0]     r_tag  [1:DS];
  logic                 r_as   [1:DS];
  logic                 r_bs   [1:DS];
  logic                 r_vld  [1:DS];

  logic                 r_out_vld;
  logic [N-1:0]         r_y;
  logic                 r_cout;
  logic                 r_ovf;
  logic [TAG_W-1:0]     r_tag_out;
  logic [N-1:0]         w_ysel;
  logic                 w_csel;

  // Whole pipeline moves in lockstep; bubbles are kept, not squeezed out.
  assign w_adv    = !r_out_vld || out_ready;
  assign in_ready = w_adv;

  assign w_b_eff  = (op == OP_SUB) ? ~b : b;
  assign w_c_eff  = (op == OP_SUB) ? ~cin : cin;

  // ---- leaf level (combinational, captured by stage 0) ----
  for (genvar j = 0; j < NL; j++) begin : g_leaf
    localparam csum_node_t P = csum_node(N, D, j);
    if (P.w > 0) begin : g_real
      csum_leaf #(.W(P.w)) u_leaf (
        .i_a  (a[P.off +: P.w]),
        .i_b  (w_b_eff[P.off +: P.w]),
        .o_y0 (w_ly0[P.off +: P.w]),
        .o_c0 (w_lc0[j]),
        .o_y1 (w_ly1[P.off +: P.w]),
        .o_c1 (w_lc1[j])
      );
    end else begin : g_empty
      // An empty chunk simply passes its carry-in through.
      assign w_lc0[j] = 1'b0;
      assign w_lc1[j] = 1'b1;
    end
  end

  assign w_y0[D]   = w_ly0;
  assign w_y1[D]   = w_ly1;
  assign w_c0[D]   = w_lc0;
  assign w_c1[D]   = w_lc1;
  assign w_ceff[D] = w_c_eff;
  assign w_tag[D]  = in_tag;
  assign w_as[D]   = a[N-1];
  assign w_bs[D]   = w_b_eff[N-1];
  assign w_vld[D]  = in_valid;

  // ---- merge levels: level l is built from the registered level l+1 ----
  for (genvar l = 0; l < D; l++) begin : g_lvl
    logic [N-1:0]  w_my0, w_my1;
    logic [NL-1:0] w_mc0, w_mc1;

    for (genvar j = 0; j < NL; j++) begin : g_node
      if (j < (1 << l)) begin : g_used
        localparam csum_node_t P  = csum_node(N, l, j);
        localparam csum_node_t H  = csum_node(N, l + 1, 2 * j + 1);
        localparam int         LW = P.w - H.w;
        logic w_lo0, w_lo1, w_hi0, w_hi1;

        assign w_lo0 = r_c0[l+1][2*j];
        assign w_lo1 = r_c1[l+1][2*j];
        assign w_hi0 = r_c0[l+1][2*j+1];
        assign w_hi1 = r_c1[l+1][2*j+1];

        // Under each hypothesis the LO carry-out picks the HI result.
        assign w_mc0[j] = w_lo0 ? w_hi1 : w_hi0;
        assign w_mc1[j] = w_lo1 ? w_hi1 : w_hi0;

        for (genvar i = 0; i < P.w; i++) begin : g_bit
          if (i < LW) begin : g_lo
            assign w_my0[P.off+i] = r_y0[l+1][P.off+i];
            assign w_my1[P.off+i] = r_y1[l+1][P.off+i];
          end else begin : g_hi
            assign w_my0[P.off+i] = w_lo0 ? r_y1[l+1][P.off+i] : r_y0[l+1][P.off+i];
            assign w_my1[P.off+i] = w_lo1 ? r_y1[l+1][P.off+i] : r_y0[l+1][P.off+i];
          end
        end
      end else begin : g_unused
        assign w_mc0[j] = 1'b0;
        assign w_mc1[j] = 1'b0;
      end
    end

    assign w_y0[l]   = w_my0;
    assign w_y1[l]   = w_my1;
    assign w_c0[l]   = w_mc0;
    assign w_c1[l]   = w_mc1;
    assign w_ceff[l] = r_ceff[l+1];
    assign w_tag[l]  = r_tag[l+1];
    assign w_as[l]   = r_as[l+1];
    assign w_bs[l]   = r_bs[l+1];
    assign w_vld[l]  = r_vld[l+1];
  end

  // ---- stages 0..D-1: tree levels D..1 ----
  if (D > 0) begin : g_pipe
    // Data registers carry no reset; their valid bit says whether they matter.
    always_ff @(posedge clk) begin
      if (w_adv) begin
        for (int l = 1; l <= D; l++) begin
          r_y0[l]   <= w_y0[l];
          r_y1[l]   <= w_y1[l];
          r_c0[l]   <= w_c0[l];
          r_c1[l]   <= w_c1[l];
          r_ceff[l] <= w_ceff[l];
          r_tag[l]  <= w_tag[l];
          r_as[l]   <= w_as[l];
          r_bs[l]   <= w_bs[l];
        end
      end
    end

    // Valid bits shift with the data and are flushed by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int l = 1; l <= D; l++) r_vld[l] <= 1'b0;
      end else if (w_adv) begin
        for (int l = 1; l <= D; l++) r_vld[l] <= w_vld[l];
      end
    end
  end

  // ---- stage D: final carry select and output register ----
  assign w_ysel = w_ceff[0] ? w_y1[0] : w_y0[0];
  assign w_csel = w_ceff[0] ? w_c1[0][0] : w_c0[0][0];

  // Output register holds while stalled; reset clears it completely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_y       <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_tag_out <= '0;
    end else if (w_adv) begin
      r_out_vld <= w_vld[0];
      r_y       <= w_ysel;
      r_cout    <= w_csel;
      r_ovf     <= (w_as[0] == w_bs[0]) && (w_ysel[N-1] != w_as[0]);
      r_tag_out <= w_tag[0];
    end
  end

  assign out_valid = r_out_vld;
  assign y         = r_y;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_tag   = r_tag_out;

endmodule
